cga_vid_out: RTL and testbench

- CGA video transmitter. Runs CGA raster timing on the pixel clock and reads 4-bit RGBI pixels from a frame memory through a fixed-latency read port.
- Drives hs, vs and the I/R/G/B lines toward the monitor-side connector.
- It is the output counterpart of the CGA acquisition path: it replays a frame buffer that the acquisition path wrote.

---
 rtl/cga_vid_out.sv | 152 +++++++++++++++
 tb/tb_cga_vid_out.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vid_out.sv
// CGA raster transmitter: generates CGA timing, fetches RGBI pixels from a frame buffer and
// drives syncs and colour lines. rd_data is captured RD_LATENCY clock edges after its address is presented.
module cga_vid_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 48,
  parameter int H_SYNC     = 64,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 200,
  parameter int V_FP       = 24,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 35,
  parameter bit H_POLARITY = 1'b1,
  parameter bit V_POLARITY = 1'b1,
  parameter int ADDR_W     = 17,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3:0]        rd_data,
  output logic              hs,
  output logic              vs,
  output logic              intensity,
  output logic              red,
  output logic              green,
  output logic              blue,
  output logic              active_video,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              at_end;
  logic              act;
  ctl_t              ctl_in;
  ctl_t              ctl_last;
  logic              av_q, fs_q, hs_q, vs_q;
  logic [3:0]        pix_q;

  always_comb begin
    at_end = (h_q == H_LAST) && (v_q == V_LAST);
    act    = (h_q < H_ACT) && (v_q < V_ACT);
    rd_en  = act && enable;

    // Disabled timing parks at the last position of the frame, so re-enabling starts a fresh frame.
    h_d = H_LAST;
    v_d = V_LAST;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end

    addr_d = addr_q;
    if (at_end) begin
      addr_d = fb_base;
    end else if (rd_en) begin
      addr_d = addr_q + 1'b1;
    end

    ctl_in     = '0;
    ctl_in.act = rd_en;
    ctl_in.hs  = enable && (h_q >= HS_BEG) && (h_q < HS_END);
    ctl_in.vs  = enable && (v_q >= VS_BEG) && (v_q < VS_END);
    ctl_in.fs  = enable && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      h_q    <= H_LAST;
      v_q    <= V_LAST;
      addr_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
    end
  end

  assign rd_addr = addr_q;

  // Control delay line: RD_LATENCY-1 stages, the output register below supplies the last one.
  generate
    if (RD_LATENCY == 1) begin : g_nodly
      assign ctl_last = ctl_in;
    end else begin : g_dly
      ctl_t dly_q [RD_LATENCY-1];
      always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= ctl_in;
          for (int i = 1; i < RD_LATENCY - 1; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign ctl_last = dly_q[RD_LATENCY-2];
    end
  endgenerate

  // Output stage: pixel data and its control captured on the same edge keeps them aligned.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      av_q  <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= ~H_POLARITY;
      vs_q  <= ~V_POLARITY;
      pix_q <= 4'h0;
    end else begin
      av_q  <= ctl_last.act;
      fs_q  <= ctl_last.fs;
      hs_q  <= ctl_last.hs ^ ~H_POLARITY;
      vs_q  <= ctl_last.vs ^ ~V_POLARITY;
      pix_q <= ctl_last.act ? rd_data : 4'h0;
    end
  end

  assign active_video = av_q;
  assign frame_start  = fs_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign {intensity, red, green, blue} = pix_q;

endmodule

// File: tb/tb_cga_vid_out.sv
// Bench for cga_vid_out: two instances (default polarity/latency 2, inverted polarity/latency 1)
// on a shrunken raster, checked against a linear-position reference model.
module tb_cga_vid_out;

  localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 6, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int TOT = HT * VT;
  localparam int LAST = TOT - 1;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] fb_base = '0;

  always #5 clk = ~clk;

  logic          rdA_en, hsA, vsA, iA, rA, gA, bA, avA, fsA;
  logic [AW-1:0] rdA_addr;
  logic [3:0]    rdA_data, pixA;
  logic          rdB_en, hsB, vsB, iB, rB, gB, bB, avB, fsB;
  logic [AW-1:0] rdB_addr;
  logic [3:0]    rdB_data, pixB;

  assign pixA = {iA, rA, gA, bA};
  assign pixB = {iB, rB, gB, bB};

  cga_vid_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POLARITY(1'b1), .V_POLARITY(1'b1), .ADDR_W(AW), .RD_LATENCY(2)
  ) dut_a (
    .clk(clk), .nRST(nRST), .enable(enable), .fb_base(fb_base),
    .rd_en(rdA_en), .rd_addr(rdA_addr), .rd_data(rdA_data),
    .hs(hsA), .vs(vsA), .intensity(iA), .red(rA), .green(gA), .blue(bA),
    .active_video(avA), .frame_start(fsA)
  );

  cga_vid_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POLARITY(1'b0), .V_POLARITY(1'b0), .ADDR_W(AW), .RD_LATENCY(1)
  ) dut_b (
    .clk(clk), .nRST(nRST), .enable(enable), .fb_base(fb_base),
    .rd_en(rdB_en), .rd_addr(rdB_addr), .rd_data(rdB_data),
    .hs(hsB), .vs(vsB), .intensity(iB), .red(rB), .green(gB), .blue(bB),
    .active_video(avB), .frame_start(fsB)
  );

  function automatic logic [3:0] mem_f(input logic [AW-1:0] a);
    return a[3:0];
  endfunction

  // Frame memories: latency 2 = one register after address capture; latency 1 = combinational.
  logic [3:0] memA_q;
  always @(posedge clk) memA_q <= mem_f(rdA_addr);
  assign rdA_data = memA_q;
  assign rdB_data = mem_f(rdB_addr);

  // Reference model: linear raster position p (LAST doubles as the parked position).
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [3:0] pix;
  } exp_t;

  int            p = LAST;
  logic [AW-1:0] fbase = '0;
  exp_t          hist [2] = '{default: '0};

  function automatic logic exp_rd();
    return enable && ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    return AW'(int'(fbase) + (p / HT) * HA + (p % HT));
  endfunction

  function automatic exp_t cur_entry();
    exp_t e;
    int x, y;
    x = p % HT;
    y = p / HT;
    e.act = enable && (x < HA) && (y < VA);
    e.hs  = enable && (x >= HA + HFP) && (x < HA + HFP + HSW);
    e.vs  = enable && (y >= VA + VFP) && (y < VA + VFP + VSW);
    e.fs  = enable && (p == 0);
    e.pix = e.act ? mem_f(exp_addr()) : 4'h0;
    return e;
  endfunction

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      p       <= LAST;
      hist[0] <= '0;
      hist[1] <= '0;
    end else begin
      hist[0] <= cur_entry();
      hist[1] <= hist[0];
      if (p == LAST) fbase <= fb_base;
      p <= enable ? (p + 1) % TOT : LAST;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    nRST = 1'b0;
    enable = 1'b1;
    fb_base = 17'h100;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== 1'b0 || rdA_addr !== '0) begin
        errors++; $display("FAIL reset_rd: rd_en=%b rd_addr=%h, required 0/0", rdA_en, rdA_addr);
      end
      checks++;
      if ({avA, hsA, vsA, fsA, pixA} !== 8'h00) begin
        errors++; $display("FAIL reset_outA: {av,hs,vs,fs,pix}=%b, required 00000000", {avA, hsA, vsA, fsA, pixA});
      end
      checks++;
      if ({avB, hsB, vsB, fsB, pixB} !== 8'b0110_0000 || rdB_addr !== '0) begin
        errors++; $display("FAIL reset_outB: {av,hs,vs,fs,pix}=%b addr=%h, required 01100000/0", {avB, hsB, vsB, fsB, pixB}, rdB_addr);
      end
    end
  endtask

  task automatic test_first_frame();
    nRST = 1'b1;
    #1;
    checks++;
    if (rdA_en !== 1'b0 || avA !== 1'b0 || rdA_addr !== '0) begin
      errors++; $display("FAIL release: rd_en=%b av=%b addr=%h, required 0/0/0", rdA_en, avA, rdA_addr);
    end
    for (int n = 1; n <= TOT + 4; n++) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== exp_rd()) begin
        errors++; $display("FAIL ff_rd_en: cycle %0d got %b required %b", n, rdA_en, exp_rd());
      end
      if (exp_rd()) begin
        checks++;
        if (rdA_addr !== exp_addr()) begin
          errors++; $display("FAIL ff_addr: cycle %0d got %h required %h", n, rdA_addr, exp_addr());
        end
      end
      checks++;
      if ({avA, hsA, vsA, fsA, pixA} !== hist[1]) begin
        errors++; $display("FAIL ff_out: cycle %0d got %b required %b", n, {avA, hsA, vsA, fsA, pixA}, hist[1]);
      end
      if (n == 1) begin
        checks++;
        if (rdA_en !== 1'b1 || rdA_addr !== 17'h100) begin
          errors++; $display("FAIL first_read: rd_en=%b addr=%h, required 1/100", rdA_en, rdA_addr);
        end
      end
      if (n == 2) begin
        checks++;
        if (avA !== 1'b0 || fsA !== 1'b0) begin
          errors++; $display("FAIL early_av: av=%b fs=%b, required 0/0", avA, fsA);
        end
      end
      if (n == 3) begin
        checks++;
        if (fsA !== 1'b1 || avA !== 1'b1 || pixA !== 4'h0) begin
          errors++; $display("FAIL first_pixel: fs=%b av=%b pix=%h, required 1/1/0", fsA, avA, pixA);
        end
      end
      if (n > 3 && n < 3 + HA) begin
        checks++;
        if (avA !== 1'b1 || fsA !== 1'b0 || pixA !== 4'((n - 3) % 16)) begin
          errors++; $display("FAIL active_run: cycle %0d av=%b fs=%b pix=%h, required 1/0/%h", n, avA, fsA, pixA, 4'((n - 3) % 16));
        end
      end
      if (n == 3 + HA) begin
        checks++;
        if (avA !== 1'b0 || pixA !== 4'h0) begin
          errors++; $display("FAIL line_end: av=%b pix=%h, required 0/0", avA, pixA);
        end
      end
    end
  endtask

  task automatic test_free_run();
    logic [AW-1:0] base;
    logic [AW-1:0] last_addr;
    logic p_hs, p_av, p_vs;
    int t_hs = -1, t_av = -1, t_vs = -1, n_vs = 0, n_start = 0, reads = 0;
    base = AW'(32'h1000 + $urandom_range(0, 32'h1_0000));
    fb_base = base;
    last_addr = '0;
    p_hs = hsA; p_av = avA; p_vs = vsA;
    for (int n = 0; n < 4 * TOT; n++) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== exp_rd() || {avA, hsA, vsA, fsA, pixA} !== hist[1]) begin
        errors++; $display("FAIL fr_model: cycle %0d rd_en=%b out=%b, required %b/%b", n, rdA_en, {avA, hsA, vsA, fsA, pixA}, exp_rd(), hist[1]);
      end
      if (rdA_en === 1'b1) begin
        if (rdA_addr === base) begin
          if (n_start > 0) begin
            checks++;
            if (reads !== HA * VA || last_addr !== AW'(base + HA * VA - 1)) begin
              errors++; $display("FAIL frame_reads: reads=%0d last=%h, required %0d/%h", reads, last_addr, HA * VA, AW'(base + HA * VA - 1));
            end
          end
          n_start++;
          reads = 0;
        end
        reads++;
        last_addr = rdA_addr;
      end
      if (avA && !p_av) t_av = n;
      if (hsA && !p_hs) begin
        if (t_hs >= 0) begin
          checks++;
          if (n - t_hs !== HT) begin
            errors++; $display("FAIL hs_period: got %0d required %0d", n - t_hs, HT);
          end
        end
        if (t_av >= 0 && n - t_av < HT) begin
          checks++;
          if (n - t_av !== HA + HFP) begin
            errors++; $display("FAIL hs_offset: got %0d required %0d", n - t_av, HA + HFP);
          end
        end
        t_hs = n;
      end
      if (!hsA && p_hs && t_hs >= 0) begin
        checks++;
        if (n - t_hs !== HSW) begin
          errors++; $display("FAIL hs_width: got %0d required %0d", n - t_hs, HSW);
        end
      end
      if (vsA && !p_vs) begin
        if (t_vs >= 0) begin
          checks++;
          if (n - t_vs !== TOT) begin
            errors++; $display("FAIL vs_period: got %0d required %0d", n - t_vs, TOT);
          end
        end
        t_vs = n;
        n_vs++;
      end
      if (!vsA && p_vs && t_vs >= 0) begin
        checks++;
        if (n - t_vs !== VSW * HT) begin
          errors++; $display("FAIL vs_width: got %0d required %0d", n - t_vs, VSW * HT);
        end
      end
      p_hs = hsA; p_av = avA; p_vs = vsA;
    end
    checks++;
    if (n_vs < 3 || n_start < 3) begin
      errors++; $display("FAIL fr_activity: vs rises=%0d frame starts=%0d, required >=3/>=3", n_vs, n_start);
    end
  endtask

  task automatic test_base_change();
    logic [AW-1:0] a1, a2;
    int k;
    for (k = 0; k < 2 * TOT && fsA !== 1'b1; k++) @(negedge clk);
    checks++;
    if (fsA !== 1'b1) begin
      errors++; $display("FAIL bc_sync: frame_start=%b after %0d cycles, required 1", fsA, k);
    end
    a1 = rdA_addr; a2 = rdA_addr;
    for (k = 0; k < 2 * TOT; k++) begin
      @(negedge clk);
      if (exp_rd()) begin
        checks++;
        if (rdA_addr !== exp_addr()) begin
          errors++; $display("FAIL bc_addr: cycle %0d got %h required %h", k, rdA_addr, exp_addr());
        end
      end
      if (fsA === 1'b1) break;
      a2 = a1;
      a1 = rdA_addr;
      if (k == 3 * HT - 2) fb_base = 17'h8000;
    end
    checks++;
    if (fsA !== 1'b1 || a2 !== 17'h8000 || pixA !== mem_f(17'h8000)) begin
      errors++; $display("FAIL bc_new_base: fs=%b addr@(0,0)=%h pix=%h, required 1/8000/%h", fsA, a2, pixA, mem_f(17'h8000));
    end
  endtask

  task automatic test_enable_drop();
    int k, x0;
    logic [AW-1:0] pa, nb;
    x0 = $urandom_range(2, HA - 3);
    for (k = 0; k < 2 * TOT && fsA !== 1'b1; k++) @(negedge clk);
    checks++;
    if (fsA !== 1'b1) begin
      errors++; $display("FAIL ed_sync: frame_start=%b, required 1", fsA);
    end
    for (k = 0; k < HT + x0 - 2; k++) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== exp_rd() || {avA, hsA, vsA, fsA, pixA} !== hist[1]) begin
        errors++; $display("FAIL ed_model: cycle %0d rd_en=%b out=%b, required %b/%b", k, rdA_en, {avA, hsA, vsA, fsA, pixA}, exp_rd(), hist[1]);
      end
    end
    pa = AW'(fbase + HA + x0 - 1);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (rdA_en !== 1'b0 || avA !== 1'b1 || pixA !== mem_f(pa)) begin
      errors++; $display("FAIL ed_drain: rd_en=%b av=%b pix=%h, required 0/1/%h", rdA_en, avA, pixA, mem_f(pa));
    end
    nb = AW'($urandom);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== 1'b0 || {avA, hsA, vsA, fsA, pixA} !== 8'h00) begin
        errors++; $display("FAIL ed_blank: hold %0d rd_en=%b out=%b, required 0/00000000", k, rdA_en, {avA, hsA, vsA, fsA, pixA});
      end
      if (k == 5) fb_base = nb;
    end
    enable = 1'b1;
    for (k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (rdA_en !== 1'b1 || rdA_addr !== nb) begin
          errors++; $display("FAIL ed_restart: rd_en=%b addr=%h, required 1/%h", rdA_en, rdA_addr, nb);
        end
      end
      checks++;
      if (fsA !== (k == 3) || avA !== (k == 3)) begin
        errors++; $display("FAIL ed_fs: clock %0d fs=%b av=%b, required %b", k, fsA, avA, k == 3);
      end
    end
  endtask

  task automatic test_pol_lat();
    logic pr;
    logic [AW-1:0] pad;
    pr = rdB_en; pad = rdB_addr;
    for (int n = 0; n < TOT + 4; n++) begin
      @(negedge clk);
      checks++;
      if (rdB_en !== exp_rd() || {avB, ~hsB, ~vsB, fsB, pixB} !== hist[0]) begin
        errors++; $display("FAIL pl_model: cycle %0d rd_en=%b out=%b, required %b/%b", n, rdB_en, {avB, ~hsB, ~vsB, fsB, pixB}, exp_rd(), hist[0]);
      end
      checks++;
      if (avB !== pr || (pr && pixB !== mem_f(pad))) begin
        errors++; $display("FAIL pl_latency: av=%b pix=%h, required %b/%h", avB, pixB, pr, pr ? mem_f(pad) : 4'h0);
      end
      pr = rdB_en; pad = rdB_addr;
    end
  endtask

  task automatic test_wrap();
    localparam logic [AW-1:0] WB = 17'h1FFF6;
    int k;
    fb_base = WB;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      for (k = 0; k < 2 * TOT && fsA !== 1'b1; k++) @(negedge clk);
    end
    checks++;
    if (fsA !== 1'b1) begin
      errors++; $display("FAIL wr_sync: frame_start=%b, required 1", fsA);
    end
    for (int j = 0; j < HA; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (avA !== 1'b1 || pixA !== mem_f(AW'(WB + j))) begin
        errors++; $display("FAIL wr_pixel: j=%0d av=%b pix=%h, required 1/%h", j, avA, pixA, mem_f(AW'(WB + j)));
      end
      if (j < HA - 2) begin
        checks++;
        if (rdA_en !== 1'b1 || rdA_addr !== AW'(WB + j + 2)) begin
          errors++; $display("FAIL wr_addr: j=%0d rd_en=%b addr=%h, required 1/%h", j, rdA_en, rdA_addr, AW'(WB + j + 2));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [AW-1:0] nb;
    repeat (2 * HT + 5) @(negedge clk);
    nRST = 1'b0;
    #1;
    checks++;
    if (rdA_en !== 1'b0 || rdA_addr !== '0 || {avA, hsA, vsA, fsA, pixA} !== 8'h00 || {hsB, vsB} !== 2'b11) begin
      errors++; $display("FAIL rm_reset: rd_en=%b addr=%h outA=%b hsB/vsB=%b", rdA_en, rdA_addr, {avA, hsA, vsA, fsA, pixA}, {hsB, vsB});
    end
    nb = AW'($urandom);
    fb_base = nb;
    @(negedge clk);
    nRST = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (fsA !== (k == 3) || rdA_en !== 1'b1 || rdA_addr !== AW'(nb + k - 1)) begin
        errors++; $display("FAIL rm_restart: clock %0d fs=%b rd_en=%b addr=%h, required %b/1/%h", k, fsA, rdA_en, rdA_addr, k == 3, AW'(nb + k - 1));
      end
    end
  endtask

  task automatic test_random_enable();
    for (int n = 0; n < 3 * TOT; n++) begin
      @(negedge clk);
      checks++;
      if (rdA_en !== exp_rd() || {avA, hsA, vsA, fsA, pixA} !== hist[1] || (exp_rd() && rdA_addr !== exp_addr())) begin
        errors++; $display("FAIL rnd_A: cycle %0d rd_en=%b addr=%h out=%b, required %b/%h/%b", n, rdA_en, rdA_addr, {avA, hsA, vsA, fsA, pixA}, exp_rd(), exp_addr(), hist[1]);
      end
      checks++;
      if (rdB_en !== exp_rd() || {avB, ~hsB, ~vsB, fsB, pixB} !== hist[0] || (exp_rd() && rdB_addr !== exp_addr())) begin
        errors++; $display("FAIL rnd_B: cycle %0d rd_en=%b addr=%h out=%b, required %b/%h/%b", n, rdB_en, rdB_addr, {avB, ~hsB, ~vsB, fsB, pixB}, exp_rd(), exp_addr(), hist[0]);
      end
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 2) fb_base = AW'($urandom);
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_free_run();
    test_base_change();
    test_enable_drop();
    test_pol_lat();
    test_wrap();
    test_reset_midframe();
    test_random_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
